// File: rtl/sync_fifo_reader_if.sv
// FIFO read port plus valid/ready stream, as seen by the FIFO reader.
// master = the reader; slave = the FIFO/sink side that surrounds it.
interface sync_fifo_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_rd_data_i;
    logic                  fifo_read_o;
    logic                  m_valid_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_ready_i;

    modport master (
        input  fifo_empty_i, fifo_rd_data_i, m_ready_i,
        output fifo_read_o, m_valid_o, m_data_o
    );

    modport slave (
        output fifo_empty_i, fifo_rd_data_i, m_ready_i,
        input  fifo_read_o, m_valid_o, m_data_o
    );
endinterface

// File: rtl/sync_fifo_reader.sv
// Read-side master for the sync FIFO: drains words into a 2-entry skid buffer
// and presents them as a valid/ready stream, hiding FIFO read latency.
module sync_fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter bit FWFT       = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    output logic [CNT_WIDTH-1:0] words_o,
    sync_fifo_reader_if.master   bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] slot0, slot1, slot0_nxt, slot1_nxt;
    logic                  inflight, pop, arr, rd;
    logic [2:0]            credit;

    assign bus.m_valid_o = (state != EMPTY);
    assign bus.m_data_o  = slot0;
    assign pop           = bus.m_valid_o & bus.m_ready_i;

    // Words held plus words already requested, net of this cycle's pop.
    // Reset also blocks reads so nothing is pulled from the FIFO and then lost.
    assign credit = {1'b0, state} + {2'b00, inflight} - {2'b00, pop};
    assign rd     = !rst_i & !bus.fifo_empty_i & !flush_i & (credit < 3'd2);
    assign bus.fifo_read_o = rd;

    generate
        if (FWFT) begin : g_fwft
            assign inflight = 1'b0;
        end else begin : g_std
            always_ff @(posedge clk_i) begin
                if (rst_i) inflight <= 1'b0;
                else       inflight <= rd;
            end
        end
    endgenerate

    assign arr = FWFT ? rd : inflight;

    always_comb begin
        state_nxt = state;
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        unique case (state)
            EMPTY: begin
                if (arr) begin
                    state_nxt = ONE;
                    slot0_nxt = bus.fifo_rd_data_i;
                end
            end
            ONE: begin
                if (arr && !pop) begin
                    state_nxt = TWO;
                    slot1_nxt = bus.fifo_rd_data_i;
                end else if (pop && !arr) begin
                    state_nxt = EMPTY;
                end else if (pop && arr) begin
                    slot0_nxt = bus.fifo_rd_data_i;
                end
            end
            TWO: begin
                if (pop) begin
                    slot0_nxt = slot1;
                    if (arr) slot1_nxt = bus.fifo_rd_data_i;
                    else     state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush drops everything held, including a word landing this edge.
        if (flush_i) state_nxt = EMPTY;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= EMPTY;
            slot0   <= '0;
            slot1   <= '0;
            words_o <= '0;
        end else begin
            state <= state_nxt;
            slot0 <= slot0_nxt;
            slot1 <= slot1_nxt;
            if (pop) words_o <= words_o + CNT_WIDTH'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(state == TWO && !pop && arr));
endmodule
